// File: rtl/axi_ss_bridge_pkg.sv
// axi_ss_bridge_pkg: shared types for the AXI4 to ss bus bridge.
// FSM states, response codes and round-robin grant select.
package axi_ss_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    R_RESP,
    W_DATA,
    WR_REQ,
    WR_WAIT,
    B_RESP
  } state_t;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } gnt_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_ss_bridge_arb.sv
// axi_ss_bridge_arb: two-requester round-robin arbiter (read vs write).
// The last-grant flag resets to write so a read wins the first tie.
module axi_ss_bridge_arb
  import axi_ss_bridge_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic rd_req_i,
  input  logic wr_req_i,
  output logic gnt_rd_o,
  output logic gnt_wr_o
);

  gnt_t last_q;
  gnt_t last_d;

  // Grant the requester not served last when both ask
  always_comb begin
    gnt_rd_o = en_i & rd_req_i &
               (~wr_req_i | (last_q == GNT_WR));
    gnt_wr_o = en_i & wr_req_i & ~gnt_rd_o;
    last_d   = last_q;
    if (gnt_rd_o)
      last_d = GNT_RD;
    else if (gnt_wr_o)
      last_d = GNT_WR;
  end

  // Remember the last accepted grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_q <= GNT_WR;
    else
      last_q <= last_d;
  end

endmodule

// File: rtl/axi_ss_bridge.sv
// axi_ss_bridge: AXI4 slave to ss bus bridge, one transaction in flight.
// Optional INCR bursts with `define AXI_SS_BRIDGE_BURST_EN.
module axi_ss_bridge
  import axi_ss_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [7:0]        S_AXI_AWLEN,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [DATA_W-1:0] S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic              S_AXI_WLAST,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [7:0]        S_AXI_ARLEN,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [DATA_W-1:0] S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RLAST,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              ss_req,
  output logic              ss_we,
  output logic [DATA_W/8-1:0] ss_be,
  output logic [ADDR_W-1:0] ss_addr,
  output logic [DATA_W-1:0] ss_wdata,
  input  logic              ss_gnt,
  input  logic              ss_rvalid,
  input  logic [DATA_W-1:0] ss_rdata,
  input  logic              ss_err
);

  localparam int BE_W = DATA_W / 8;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [BE_W-1:0]     be_q;
  logic [1:0]          rresp_q;
  logic [1:0]          bresp_q;
  logic                rvalid_q;
  logic                rlast_q;
  logic                bvalid_q;
  logic                wready_q;
  logic                req_q;
  logic                we_q;
  logic                gnt_rd;
  logic                gnt_wr;
  logic                last_beat;

`ifdef AXI_SS_BRIDGE_BURST_EN
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BE_W);
  logic [7:0] cnt_q;
  logic [7:0] len_q;
  logic       unused_in;
  assign last_beat = (cnt_q == len_q);
  assign unused_in = S_AXI_WLAST;
`else
  logic unused_in;
  assign last_beat = 1'b1;
  assign unused_in = ^{S_AXI_ARLEN, S_AXI_AWLEN, S_AXI_WLAST};
`endif

  axi_ss_bridge_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .en_i     ((state_q == IDLE) & ~reset),
    .rd_req_i (S_AXI_ARVALID),
    .wr_req_i (S_AXI_AWVALID),
    .gnt_rd_o (gnt_rd),
    .gnt_wr_o (gnt_wr)
  );

  assign S_AXI_ARREADY = gnt_rd;
  assign S_AXI_AWREADY = gnt_wr;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign ss_req        = req_q;
  assign ss_we         = we_q;
  assign ss_be         = be_q;
  assign ss_addr       = addr_q;
  assign ss_wdata      = wdata_q;

  // Bridge FSM with registered AXI and ss outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      rresp_q  <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      bvalid_q <= 1'b0;
      wready_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
`ifdef AXI_SS_BRIDGE_BURST_EN
      cnt_q    <= '0;
      len_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_rd) begin
            addr_q  <= S_AXI_ARADDR;
            be_q    <= '1;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            state_q <= RD_REQ;
`ifdef AXI_SS_BRIDGE_BURST_EN
            len_q   <= S_AXI_ARLEN;
            cnt_q   <= '0;
`endif
          end else if (gnt_wr) begin
            addr_q   <= S_AXI_AWADDR;
            bresp_q  <= RESP_OKAY;
            wready_q <= 1'b1;
            state_q  <= W_DATA;
`ifdef AXI_SS_BRIDGE_BURST_EN
            len_q    <= S_AXI_AWLEN;
            cnt_q    <= '0;
`endif
          end
        end
        RD_REQ: begin
          if (ss_gnt) begin
            req_q   <= 1'b0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (ss_rvalid) begin
            rdata_q  <= ss_rdata;
            rresp_q  <= resp_of(ss_err);
            rvalid_q <= 1'b1;
            rlast_q  <= last_beat;
            state_q  <= R_RESP;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            state_q  <= IDLE;
`ifdef AXI_SS_BRIDGE_BURST_EN
            if (!last_beat) begin
              cnt_q   <= cnt_q + 8'd1;
              addr_q  <= addr_q + STEP;
              req_q   <= 1'b1;
              state_q <= RD_REQ;
            end
`endif
          end
        end
        W_DATA: begin
          if (S_AXI_WVALID) begin
            wready_q <= 1'b0;
            wdata_q  <= S_AXI_WDATA;
            be_q     <= S_AXI_WSTRB;
            req_q    <= 1'b1;
            we_q     <= 1'b1;
            state_q  <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (ss_gnt) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (ss_rvalid) begin
            if (ss_err)
              bresp_q <= RESP_SLVERR;
            bvalid_q <= 1'b1;
            state_q  <= B_RESP;
`ifdef AXI_SS_BRIDGE_BURST_EN
            if (!last_beat) begin
              bvalid_q <= 1'b0;
              cnt_q    <= cnt_q + 8'd1;
              addr_q   <= addr_q + STEP;
              wready_q <= 1'b1;
              state_q  <= W_DATA;
            end
`endif
          end
        end
        B_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ss_bridge.sv
// tb_axi_ss_bridge: directed AXI traffic, ss responder model and
// a scoreboard monitor that checks every handshake against queues.
module tb_axi_ss_bridge;
  import axi_ss_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        ss_req;
  logic        ss_we;
  logic [3:0]  ss_be;
  logic [31:0] ss_addr;
  logic [31:0] ss_wdata;
  logic        ss_gnt;
  logic        ss_rvalid = 1'b0;
  logic [31:0] ss_rdata = '0;
  logic        ss_err = 1'b0;

  logic gnt_en = 1'b1;
  logic ss_hold = 1'b0;

  always #5 clk = ~clk;
  assign ss_gnt = ss_req && gnt_en;

  axi_ss_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .ss_req(ss_req), .ss_we(ss_we), .ss_be(ss_be),
    .ss_addr(ss_addr), .ss_wdata(ss_wdata),
    .ss_gnt(ss_gnt), .ss_rvalid(ss_rvalid),
    .ss_rdata(ss_rdata), .ss_err(ss_err)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ss_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } ss_rsp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    int          lat;
  } r_exp_t;

  ss_exp_t    ss_q[$];
  ss_rsp_t    rsp_q[$];
  r_exp_t     r_q[$];
  logic [1:0] b_q[$];
  logic       g_q[$];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s: got event want none", nm);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ss responder: completion one cycle after the accepted request
  logic hs_n = 1'b0;
  always @(negedge clk) hs_n = ss_req && ss_gnt && !reset;

  always @(posedge clk) begin
    ss_rsp_t r;
    logic hs;
    hs = hs_n;
    #1;
    ss_rvalid = 1'b0;
    ss_err = 1'b0;
    ss_rdata = 32'h5A5A5A5A;
    if (hs && !reset && rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      if (!ss_hold) begin
        ss_rvalid = 1'b1;
        ss_rdata = r.data;
        ss_err = r.err;
      end
    end
  end

  // Monitor: pops expectations on every DUT handshake
  logic        pr_rstall = 1'b0;
  logic [34:0] pr_r = '0;
  logic        pr_sstall = 1'b0;
  logic [68:0] pr_s = '0;
  logic        pr_rv = 1'b0;
  int          ar_cyc = 0;

  always @(negedge clk) begin
    ss_exp_t e;
    r_exp_t  x;
    logic    g;
    logic [1:0] b;
    if (reset) begin
      pr_rstall = 1'b0;
      pr_sstall = 1'b0;
      pr_rv = 1'b0;
    end else begin
      if (arvalid && arready) begin
        ar_cyc = cyc;
        if (g_q.size() == 0) bad("ar_unexpected");
        else begin
          g = g_q.pop_front();
          chk("grant_rd", 64'(1'b0), 64'(g));
        end
      end
      if (awvalid && awready) begin
        if (g_q.size() == 0) bad("aw_unexpected");
        else begin
          g = g_q.pop_front();
          chk("grant_wr", 64'(1'b1), 64'(g));
        end
      end
      if (pr_sstall)
        chk("ss_stable", 64'({ss_req, ss_we, ss_be, ss_addr}),
            64'({1'b1, pr_s[68:32]}));
      if (ss_req && ss_gnt) begin
        if (ss_q.size() == 0) bad("ss_unexpected");
        else begin
          e = ss_q.pop_front();
          chk("ss_we_be_addr", 64'({ss_we, ss_be, ss_addr}),
              64'({e.we, e.be, e.addr}));
          if (e.we) chk("ss_wdata", 64'(ss_wdata), 64'(e.wdata));
        end
      end
      if (pr_rstall)
        chk("r_stable", 64'({rvalid, rdata, rresp, rlast}),
            64'({1'b1, pr_r}));
      if (rvalid && !pr_rv && r_q.size() > 0 && r_q[0].lat >= 0)
        chk("r_latency", 64'(cyc - ar_cyc), 64'(r_q[0].lat));
      if (rvalid && rready) begin
        if (r_q.size() == 0) bad("r_unexpected");
        else begin
          x = r_q.pop_front();
          chk("r_data_resp_last", 64'({rdata, rresp, rlast}),
              64'({x.data, x.resp, x.last}));
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) bad("b_unexpected");
        else begin
          b = b_q.pop_front();
          chk("b_resp", 64'(bresp), 64'(b));
        end
      end
      pr_rv = rvalid;
      pr_rstall = rvalid && !rready;
      pr_r = {rdata, rresp, rlast};
      pr_sstall = ss_req && !ss_gnt;
      pr_s = {ss_we, ss_be, ss_addr, ss_wdata};
    end
  end

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len);
    int n;
    araddr = a;
    arlen = len;
    arvalid = 1'b1;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (arready) break;
    end
    if (n == 60) bad("ar_timeout");
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a);
    int n;
    awaddr = a;
    awlen = 8'd0;
    awvalid = 1'b1;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (awready) break;
    end
    if (n == 60) bad("aw_timeout");
    @(posedge clk);
    #1 awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    int n;
    wdata = d;
    wstrb = s;
    wlast = 1'b1;
    wvalid = 1'b1;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (wready) break;
    end
    if (n == 60) bad("w_timeout");
    @(posedge clk);
    #1 wvalid = 1'b0;
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [31:0] d,
                        input logic err, input int lat);
    ss_q.push_back('{1'b0, 4'hF, a, 32'h0});
    rsp_q.push_back('{d, err});
    r_q.push_back('{d, err ? 2'b10 : 2'b00, 1'b1, lat});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic err);
    ss_q.push_back('{1'b1, s, a, d});
    rsp_q.push_back('{32'h0, err});
    b_q.push_back(err ? 2'b10 : 2'b00);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ss_q.size() == 0 && r_q.size() == 0 &&
          b_q.size() == 0 && g_q.size() == 0) break;
    end
    if (n == 200) bad("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d,
                    input logic err, input int lat);
    g_q.push_back(1'b0);
    exp_rd(a, d, err, lat);
    ar_send(a, 8'd0);
    drain();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic err);
    g_q.push_back(1'b1);
    exp_wr(a, d, s, err);
    aw_send(a);
    w_send(d, s);
    drain();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        64'({awready, wready, bvalid, bresp, arready, rvalid,
             rresp, rlast, ss_req, ss_we}), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Simultaneous AR/AW: grants alternate R, W, R, W
    g_q.push_back(1'b0);
    exp_rd(32'h0000_1000, 32'h1111_0001, 1'b0, 3);
    g_q.push_back(1'b1);
    exp_wr(32'h0000_2000, 32'hA0A0_0001, 4'hF, 1'b0);
    g_q.push_back(1'b0);
    exp_rd(32'h0000_1004, 32'h1111_0002, 1'b0, -1);
    g_q.push_back(1'b1);
    exp_wr(32'h0000_2004, 32'hA0A0_0002, 4'hC, 1'b0);
    fork
      begin
        ar_send(32'h0000_1000, 8'd0);
        ar_send(32'h0000_1004, 8'd0);
      end
      begin
        aw_send(32'h0000_2000);
        w_send(32'hA0A0_0001, 4'hF);
        aw_send(32'h0000_2004);
        w_send(32'hA0A0_0002, 4'hC);
      end
    join
    drain();

    rd(32'h8000_1000, 32'hDEAD_BEEF, 1'b0, 3);
    wr(32'h9a10_0000, 32'h0000_0001, 4'b0011, 1'b0);
    wr(32'h0000_0040, 32'hCAFE_F00D, 4'b1000, 1'b1);

    // Error read with RREADY held low for 5 cycles
    rready = 1'b0;
    g_q.push_back(1'b0);
    exp_rd(32'h0000_0100, 32'h1234_5678, 1'b1, 3);
    ar_send(32'h0000_0100, 8'd0);
    begin
      int n;
      for (n = 0; n < 50; n++) begin
        @(negedge clk);
        if (rvalid) break;
      end
      if (n == 50) bad("rvalid_timeout");
    end
    repeat (5) @(posedge clk);
    #1 rready = 1'b1;
    drain();

    // Delayed ss grant: request must hold steady
    gnt_en = 1'b0;
    g_q.push_back(1'b0);
    exp_rd(32'h0000_0200, 32'h0BAD_CAFE, 1'b0, -1);
    ar_send(32'h0000_0200, 8'd0);
    repeat (3) @(posedge clk);
    #1 gnt_en = 1'b1;
    drain();

`ifdef AXI_SS_BRIDGE_BURST_EN
    g_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      ss_q.push_back('{1'b0, 4'hF, 32'h8000_0000 + 32'(4 * i), 32'h0});
      rsp_q.push_back('{32'hB000_0000 + 32'(i), 1'b0});
      r_q.push_back('{32'hB000_0000 + 32'(i), 2'b00, i == 3, -1});
    end
    ar_send(32'h8000_0000, 8'd3);
    drain();
`else
    g_q.push_back(1'b0);
    exp_rd(32'h8000_0000, 32'hB000_0000, 1'b0, 3);
    ar_send(32'h8000_0000, 8'd3);
    drain();
`endif

    // Reset while waiting for a write ack
    ss_hold = 1'b1;
    g_q.push_back(1'b1);
    ss_q.push_back('{1'b1, 4'hF, 32'h0000_0300, 32'h7777_7777});
    rsp_q.push_back('{32'h0, 1'b0});
    aw_send(32'h0000_0300);
    w_send(32'h7777_7777, 4'hF);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_outputs",
        64'({awready, wready, bvalid, bresp, arready, rvalid,
             rresp, rlast, ss_req, ss_we}), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    ss_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr(32'h0000_0304, 32'h8888_8888, 4'hF, 1'b0);

    repeat (4) @(posedge clk);
    if (ss_q.size() + r_q.size() + b_q.size() + g_q.size() != 0)
      bad("leftover_expectations");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1);
  end

endmodule
